// File: rtl/hwpe_sm_port_arbiter.sv
// Shares one TCDM LINT master port among N_REQ requesters, round-robin; define
// HWPE_SM_ARB_FIXED_PRIO_EN for fixed lowest-index priority. Request/grant paths are combinational.
module hwpe_sm_port_arbiter #(
  parameter int N_REQ           = 2,
  parameter int CLUS_ADDR_WIDTH = 32,
  parameter int CLUS_DATA_WIDTH = 32,
  parameter int CLUS_BE_WIDTH   = CLUS_DATA_WIDTH/8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_REQ-1:0]                     req_i,
  output logic [N_REQ-1:0]                     gnt_o,
  input  logic [N_REQ*CLUS_ADDR_WIDTH-1:0]     add_i,
  input  logic [N_REQ-1:0]                     type_i,
  input  logic [N_REQ*CLUS_BE_WIDTH-1:0]       be_i,
  input  logic [N_REQ*CLUS_DATA_WIDTH-1:0]     data_i,
  output logic [CLUS_DATA_WIDTH-1:0]           r_data_o,
  output logic [N_REQ-1:0]                     r_valid_o,
  output logic                                 tcdm_req_o,
  input  logic                                 tcdm_gnt_i,
  output logic [CLUS_ADDR_WIDTH-1:0]           tcdm_add_o,
  output logic                                 tcdm_type_o,
  output logic [CLUS_BE_WIDTH-1:0]             tcdm_be_o,
  output logic [CLUS_DATA_WIDTH-1:0]           tcdm_data_o,
  input  logic [CLUS_DATA_WIDTH-1:0]           tcdm_r_data_i,
  input  logic                                 tcdm_r_valid_i,
  output logic                                 err_o
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [0:0] ARB  = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  logic [0:0]       state;
  logic [IDX_W-1:0] own;
  logic [IDX_W-1:0] base;
  logic [IDX_W-1:0] arb_w;
  logic [IDX_W-1:0] win;
  logic [IDX_W-1:0] rsp_id;
  logic [IDX_W:0]   cand;
  logic             rsp_pend;
  logic             err;
  logic             lock_drop;
  logic             hs;

`ifdef HWPE_SM_ARB_FIXED_PRIO_EN
  assign base = '0;
`else
  logic [IDX_W-1:0] ptr;
  assign base = ptr;

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (hs)
      ptr <= (win == IDX_W'(N_REQ-1)) ? '0 : win + IDX_W'(1);
  end
`endif

  // Scan from the farthest candidate down so the one nearest base is written last and wins.
  always_comb begin
    arb_w = '0;
    cand  = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      cand = {1'b0, base} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_REQ))
        cand = cand - (IDX_W+1)'(N_REQ);
      if (req_i[cand[IDX_W-1:0]])
        arb_w = cand[IDX_W-1:0];
    end
  end

  assign lock_drop   = (state == LOCK) && !req_i[own];
  assign win         = (state == LOCK) ? own : arb_w;
  assign tcdm_req_o  = (state == LOCK) ? req_i[own] : |req_i;
  assign hs          = tcdm_req_o & tcdm_gnt_i;

  assign tcdm_add_o  = add_i[win*CLUS_ADDR_WIDTH +: CLUS_ADDR_WIDTH];
  assign tcdm_type_o = type_i[win];
  assign tcdm_be_o   = be_i[win*CLUS_BE_WIDTH +: CLUS_BE_WIDTH];
  assign tcdm_data_o = data_i[win*CLUS_DATA_WIDTH +: CLUS_DATA_WIDTH];
  assign r_data_o    = tcdm_r_data_i;
  assign err_o       = err;

  always_comb begin
    gnt_o     = '0;
    r_valid_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      gnt_o[i]     = hs && (win == IDX_W'(i));
      r_valid_o[i] = tcdm_r_valid_i && rsp_pend && (rsp_id == IDX_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB;
      own      <= '0;
      rsp_pend <= 1'b0;
      rsp_id   <= '0;
      err      <= 1'b0;
    end else begin
      rsp_pend <= hs;
      if (hs)
        rsp_id <= win;
      // A response with nothing outstanding is dropped, not routed.
      if (lock_drop || (tcdm_r_valid_i && !rsp_pend))
        err <= 1'b1;
      case (state)
        ARB: begin
          if (tcdm_req_o && !tcdm_gnt_i) begin
            state <= LOCK;
            own   <= win;
          end
        end
        default: begin
          if (tcdm_gnt_i || lock_drop)
            state <= ARB;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hwpe_sm_port_arbiter.sv
// Directed bench for hwpe_sm_port_arbiter: a 2-requester and a 3-requester instance.
module tb_hwpe_sm_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
`ifdef HWPE_SM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0]      a_req, a_gnt, a_type, a_rvalid;
  logic [2*AW-1:0] a_add;
  logic [2*BW-1:0] a_be;
  logic [2*DW-1:0] a_data;
  logic [DW-1:0]   a_rdata, a_tdata, a_trdata;
  logic [AW-1:0]   a_tadd;
  logic [BW-1:0]   a_tbe;
  logic            a_treq, a_tgnt, a_ttype, a_trvalid, a_err;

  logic [2:0]      b_req, b_gnt, b_type, b_rvalid;
  logic [3*AW-1:0] b_add;
  logic [3*BW-1:0] b_be;
  logic [3*DW-1:0] b_data;
  logic [DW-1:0]   b_rdata, b_tdata, b_trdata;
  logic [AW-1:0]   b_tadd;
  logic [BW-1:0]   b_tbe;
  logic            b_treq, b_tgnt, b_ttype, b_trvalid, b_err;

  hwpe_sm_port_arbiter #(.N_REQ(2)) dut2 (
    .clk(clk), .rst(rst), .req_i(a_req), .gnt_o(a_gnt), .add_i(a_add), .type_i(a_type),
    .be_i(a_be), .data_i(a_data), .r_data_o(a_rdata), .r_valid_o(a_rvalid),
    .tcdm_req_o(a_treq), .tcdm_gnt_i(a_tgnt), .tcdm_add_o(a_tadd), .tcdm_type_o(a_ttype),
    .tcdm_be_o(a_tbe), .tcdm_data_o(a_tdata), .tcdm_r_data_i(a_trdata),
    .tcdm_r_valid_i(a_trvalid), .err_o(a_err)
  );

  hwpe_sm_port_arbiter #(.N_REQ(3)) dut3 (
    .clk(clk), .rst(rst), .req_i(b_req), .gnt_o(b_gnt), .add_i(b_add), .type_i(b_type),
    .be_i(b_be), .data_i(b_data), .r_data_o(b_rdata), .r_valid_o(b_rvalid),
    .tcdm_req_o(b_treq), .tcdm_gnt_i(b_tgnt), .tcdm_add_o(b_tadd), .tcdm_type_o(b_ttype),
    .tcdm_be_o(b_tbe), .tcdm_data_o(b_tdata), .tcdm_r_data_i(b_trdata),
    .tcdm_r_valid_i(b_trvalid), .err_o(b_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    a_req = '0; a_tgnt = 1'b0; a_trvalid = 1'b0; a_trdata = '0;
    a_add = {32'h0000_0200, 32'h0000_0100}; a_be = {4'hC, 4'h3};
    a_data = {32'h0000_BBBB, 32'h0000_AAAA}; a_type = 2'b10;
    b_req = '0; b_tgnt = 1'b0; b_trvalid = 1'b0; b_trdata = '0;
    b_add = {32'h300, 32'h200, 32'h100}; b_be = '0; b_data = '0; b_type = '0;
    tick; tick;
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (a_treq !== 1'b0) begin n_fail++; $display("FAIL reset_treq got %b want 0", a_treq); end
    n_checks++; if (a_gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt got %b want 00", a_gnt); end
    n_checks++; if (a_rvalid !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid got %b want 00", a_rvalid); end
    n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", a_err); end
    n_checks++; if (a_tadd !== 32'h100) begin n_fail++; $display("FAIL reset_idle_add got %h want 100", a_tadd); end
    tick;
  endtask

  task automatic test_round_robin;
    logic [1:0] eg [5];
    logic [1:0] ev [5];
    eg = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
    ev = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10};
    if (FIXED) begin
      eg = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
      ev = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01};
    end
    for (int c = 0; c < 5; c++) begin
      a_req = (c < 4) ? 2'b11 : 2'b00;
      a_tgnt = (c < 4);
      a_trvalid = (c > 0);
      a_trdata = 32'hD000 + c;
      @(negedge clk);
      n_checks++; if (a_gnt !== eg[c]) begin n_fail++; $display("FAIL rr_gnt c%0d got %b want %b", c, a_gnt, eg[c]); end
      n_checks++; if (a_rvalid !== ev[c]) begin n_fail++; $display("FAIL rr_rvalid c%0d got %b want %b", c, a_rvalid, ev[c]); end
      n_checks++; if (a_rdata !== 32'hD000 + c) begin n_fail++; $display("FAIL rr_rdata c%0d got %h want %h", c, a_rdata, 32'hD000 + c); end
      tick;
    end
    a_trvalid = 1'b0;
    @(negedge clk);
    n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL rr_err got %b want 0", a_err); end
    tick;
  endtask

  task automatic test_stall_lock;
    logic [1:0]  rq [6];
    logic [1:0]  eg [6];
    logic [1:0]  ev [6];
    logic [31:0] ea [6];
    rq = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
    eg = '{2'b00, 2'b00, 2'b00, 2'b01, FIXED ? 2'b01 : 2'b10, 2'b00};
    ev = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, FIXED ? 2'b01 : 2'b10};
    ea = '{32'h100, 32'h100, 32'h100, 32'h100, FIXED ? 32'h100 : 32'h200, 32'h100};
    for (int c = 0; c < 6; c++) begin
      a_req = rq[c];
      a_tgnt = (c == 3 || c == 4);
      a_trvalid = (c >= 4);
      @(negedge clk);
      n_checks++; if (a_tadd !== ea[c]) begin n_fail++; $display("FAIL stall_add c%0d got %h want %h", c, a_tadd, ea[c]); end
      n_checks++; if (a_gnt !== eg[c]) begin n_fail++; $display("FAIL stall_gnt c%0d got %b want %b", c, a_gnt, eg[c]); end
      n_checks++; if (a_rvalid !== ev[c]) begin n_fail++; $display("FAIL stall_rvalid c%0d got %b want %b", c, a_rvalid, ev[c]); end
      if (c == 4) begin
        n_checks++; if (a_tbe !== (FIXED ? 4'h3 : 4'hC)) begin n_fail++; $display("FAIL stall_be got %h want %h", a_tbe, FIXED ? 4'h3 : 4'hC); end
        n_checks++; if (a_ttype !== !FIXED) begin n_fail++; $display("FAIL stall_type got %b want %b", a_ttype, !FIXED); end
      end
      tick;
    end
    a_trvalid = 1'b0;
  endtask

  task automatic test_single_requester;
    for (int c = 0; c < 4; c++) begin
      a_req = (c < 3) ? 2'b10 : 2'b00;
      a_tgnt = (c < 3);
      a_trvalid = (c > 0);
      @(negedge clk);
      n_checks++; if (a_gnt !== ((c < 3) ? 2'b10 : 2'b00)) begin n_fail++; $display("FAIL single_gnt c%0d got %b", c, a_gnt); end
      n_checks++; if (a_rvalid !== ((c > 0) ? 2'b10 : 2'b00)) begin n_fail++; $display("FAIL single_rvalid c%0d got %b", c, a_rvalid); end
      n_checks++; if (a_tdata !== ((c < 3) ? 32'hBBBB : 32'hAAAA)) begin n_fail++; $display("FAIL single_data c%0d got %h", c, a_tdata); end
      tick;
    end
    a_trvalid = 1'b0;
  endtask

  task automatic test_fixed_prio;
`ifdef HWPE_SM_ARB_FIXED_PRIO_EN
    for (int c = 0; c < 4; c++) begin
      a_req = 2'b11; a_tgnt = 1'b1; a_trvalid = (c > 0);
      @(negedge clk);
      n_checks++; if (a_gnt !== 2'b01) begin n_fail++; $display("FAIL fixed_gnt c%0d got %b want 01", c, a_gnt); end
      tick;
    end
    a_req = '0; a_tgnt = 1'b0; a_trvalid = 1'b1;
    @(negedge clk);
    n_checks++; if (a_rvalid !== 2'b01) begin n_fail++; $display("FAIL fixed_rvalid got %b want 01", a_rvalid); end
    tick;
    a_trvalid = 1'b0;
`endif
  endtask

  task automatic test_lock_drop_err;
    a_req = 2'b01; a_tgnt = 1'b0;
    @(negedge clk);
    n_checks++; if (a_treq !== 1'b1) begin n_fail++; $display("FAIL drop_treq0 got %b want 1", a_treq); end
    n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL drop_err0 got %b want 0", a_err); end
    tick;
    a_req = 2'b00;
    @(negedge clk);
    n_checks++; if (a_treq !== 1'b0) begin n_fail++; $display("FAIL drop_treq1 got %b want 0", a_treq); end
    tick;
    a_req = 2'b10;
    @(negedge clk);
    n_checks++; if (a_err !== 1'b1) begin n_fail++; $display("FAIL drop_err1 got %b want 1", a_err); end
    n_checks++; if (a_tadd !== 32'h200) begin n_fail++; $display("FAIL drop_arb_add got %h want 200", a_tadd); end
    tick;
    a_tgnt = 1'b1;
    @(negedge clk);
    n_checks++; if (a_gnt !== 2'b10) begin n_fail++; $display("FAIL drop_gnt got %b want 10", a_gnt); end
    tick;
    a_req = 2'b00; a_tgnt = 1'b0; a_trvalid = 1'b1;
    @(negedge clk);
    n_checks++; if (a_rvalid !== 2'b10) begin n_fail++; $display("FAIL drop_rvalid got %b want 10", a_rvalid); end
    tick;
    a_trvalid = 1'b0;
  endtask

  task automatic test_reset_in_lock;
    a_req = 2'b01; a_tgnt = 1'b1;
    @(negedge clk);
    n_checks++; if (a_gnt !== 2'b01) begin n_fail++; $display("FAIL rl_gnt got %b want 01", a_gnt); end
    tick;
    a_req = 2'b11; a_tgnt = 1'b0; a_trvalid = 1'b1;
    @(negedge clk);
    n_checks++; if (a_tadd !== (FIXED ? 32'h100 : 32'h200)) begin n_fail++; $display("FAIL rl_lock_add got %h", a_tadd); end
    n_checks++; if (a_rvalid !== 2'b01) begin n_fail++; $display("FAIL rl_rvalid got %b want 01", a_rvalid); end
    tick;
    rst = 1'b1; a_trvalid = 1'b0;
    tick;
    rst = 1'b0; a_trvalid = 1'b1;
    @(negedge clk);
    n_checks++; if (a_tadd !== 32'h100) begin n_fail++; $display("FAIL rl_post_add got %h want 100", a_tadd); end
    n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL rl_post_err got %b want 0", a_err); end
    n_checks++; if (a_rvalid !== 2'b00) begin n_fail++; $display("FAIL rl_orphan_rvalid got %b want 00", a_rvalid); end
    tick;
    a_req = 2'b00; a_trvalid = 1'b0;
    @(negedge clk);
    n_checks++; if (a_err !== 1'b1) begin n_fail++; $display("FAIL rl_orphan_err got %b want 1", a_err); end
    tick;
  endtask

  task automatic test_wrap3;
    logic [2:0] eg [5];
    logic [2:0] ev [5];
    eg = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b000};
    ev = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b001};
    if (FIXED) begin
      eg = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000};
      ev = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b001};
    end
    for (int c = 0; c < 5; c++) begin
      b_req = (c < 4) ? 3'b111 : 3'b000;
      b_tgnt = (c < 4);
      b_trvalid = (c > 0);
      @(negedge clk);
      n_checks++; if (b_gnt !== eg[c]) begin n_fail++; $display("FAIL wrap3_gnt c%0d got %b want %b", c, b_gnt, eg[c]); end
      n_checks++; if (b_rvalid !== ev[c]) begin n_fail++; $display("FAIL wrap3_rvalid c%0d got %b want %b", c, b_rvalid, ev[c]); end
      tick;
    end
    b_trvalid = 1'b0;
    @(negedge clk);
    n_checks++; if (b_err !== 1'b0) begin n_fail++; $display("FAIL wrap3_err got %b want 0", b_err); end
    tick;
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_stall_lock;
    test_single_requester;
    test_fixed_prio;
    test_lock_drop_err;
    test_reset_in_lock;
    test_wrap3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
